// File: rtl/sa_sequencer.sv
// Sequencer for one systolic_array multiply. It holds operand matrices A and B,
// clears the array, feeds the skewed wavefront, waits for the array to drain,
// and then streams the DIM x DIM result row-major over a valid/ready port.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | operand writes accepted, waiting for start
// S_CLEAR | one cycle with sa_clear_n low, feeds zero
// S_FEED  | wavefront t = 0 .. 3*DIM-3 on sa_left / sa_top
// S_DRAIN | feeds zero; DRAIN cycles of array latency plus one sample cycle
// S_OUT   | result beats k = 0 .. DIM*DIM-1, held while out_ready is low
module sa_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIM   = 10,
  parameter int DRAIN = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  wr_en,
  input  logic                                  wr_sel,
  input  logic [$clog2(DIM)-1:0]                wr_row,
  input  logic [$clog2(DIM)-1:0]                wr_col,
  input  logic [WIDTH-1:0]                      wr_data,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sa_clear_n,
  output logic [DIM-1:0][WIDTH-1:0]             sa_left,
  output logic [DIM-1:0][WIDTH-1:0]             sa_top,
  input  logic [DIM-1:0][DIM-1:0][2*WIDTH-1:0]  sa_result,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [2*WIDTH-1:0]                    out_data,
  output logic [$clog2(DIM)-1:0]                out_row,
  output logic [$clog2(DIM)-1:0]                out_col,
  output logic                                  out_last
);

  localparam int IW       = $clog2(DIM);
  localparam int FEED_LEN = 3 * DIM - 2;
  localparam int TW       = $clog2(FEED_LEN);
  localparam int DW       = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(FEED_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIM - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUT} state_t;

  state_t                      state;
  logic [WIDTH-1:0]            mem_a [DIM][DIM];
  logic [WIDTH-1:0]            mem_b [DIM][DIM];
  logic [TW-1:0]               t_cnt;
  logic [TW-1:0]               t_nxt;
  logic [DW-1:0]               drain_cnt;
  logic [DIM-1:0][WIDTH-1:0]   left_nxt;
  logic [DIM-1:0][WIDTH-1:0]   top_nxt;
  logic [IW-1:0]               row_nxt;
  logic [IW-1:0]               col_nxt;

  // Operand buffers: written only while idle and only for in-range indices.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && wr_en && wr_row <= IDX_LAST && wr_col <= IDX_LAST) begin
      if (wr_sel) mem_b[wr_row][wr_col] <= wr_data;
      else        mem_a[wr_row][wr_col] <= wr_data;
    end
  end

  // Wavefront index for the next feed cycle; CLEAR seeds t = 0.
  always_comb begin
    t_nxt = (state == S_CLEAR) ? '0 : t_cnt + TW'(1);
  end

  for (genvar gi = 0; gi < DIM; gi++) begin : g_feed
    logic [WIDTH-1:0] l_val;
    logic [WIDTH-1:0] t_val;

    // Skewed operand for row/column gi: element (t - gi) when it lies inside the matrix.
    always_comb begin
      int k;
      k     = int'(t_nxt) - gi;
      l_val = '0;
      t_val = '0;
      if (k >= 0 && k < DIM) begin
        l_val = mem_a[gi][IW'(k)];
        t_val = mem_b[IW'(k)][gi];
      end
    end

    assign left_nxt[gi] = l_val;
    assign top_nxt[gi]  = t_val;
  end

  // Row-major successor of the current output index.
  always_comb begin
    row_nxt = out_row;
    col_nxt = out_col + IW'(1);
    if (out_col == IDX_LAST) begin
      col_nxt = '0;
      row_nxt = out_row + IW'(1);
    end
  end

  // Sequencing FSM; every output is registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sa_clear_n <= 1'b0;
      sa_left    <= '0;
      sa_top     <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      t_cnt      <= '0;
      drain_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          sa_clear_n <= 1'b1;
          busy       <= 1'b0;
          if (start) begin
            state      <= S_CLEAR;
            busy       <= 1'b1;
            sa_clear_n <= 1'b0;
          end
        end
        S_CLEAR: begin
          sa_clear_n <= 1'b1;
          t_cnt      <= t_nxt;
          sa_left    <= left_nxt;
          sa_top     <= top_nxt;
          state      <= S_FEED;
        end
        S_FEED: begin
          if (t_cnt == T_LAST) begin
            sa_left   <= '0;
            sa_top    <= '0;
            drain_cnt <= DW'(DRAIN);
            state     <= S_DRAIN;
          end else begin
            t_cnt   <= t_nxt;
            sa_left <= left_nxt;
            sa_top  <= top_nxt;
          end
        end
        S_DRAIN: begin
          // Terminal count doubles as the cycle that samples the first result.
          if (drain_cnt == '0) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            out_data  <= sa_result[0][0];
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              out_row  <= row_nxt;
              out_col  <= col_nxt;
              out_data <= sa_result[row_nxt][col_nxt];
              out_last <= (row_nxt == IDX_LAST) && (col_nxt == IDX_LAST);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
